// File: rtl/gpu_mem_req_arb.sv
// Round-robin memory request arbiter with in-order response steering via a tag FIFO.
// Optional sticky unexpected-response check: define GPU_MEM_REQ_ERR_CHECK_EN.
package constants_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
endpackage

module gpu_mem_req_arb_rsp_lane (
    input  logic sel_i,
    input  logic vld_i,
    output logic vld_o
);
    assign vld_o = sel_i & vld_i;
endmodule

module gpu_mem_req_arb #(
    parameter int NUM_CLIENTS     = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_CLIENTS-1:0]                        c_req_vld,
    output logic [NUM_CLIENTS-1:0]                        c_req_rdy,
    input  logic [NUM_CLIENTS*constants_pkg::ADDR_WIDTH-1:0] c_req_addr,
    output logic [NUM_CLIENTS-1:0]                        c_rsp_vld,
    input  logic [NUM_CLIENTS-1:0]                        c_rsp_rdy,
    output logic [constants_pkg::DATA_WIDTH-1:0]          c_rsp_data,
    output logic                                          m_req_vld,
    input  logic                                          m_req_rdy,
    output logic [constants_pkg::ADDR_WIDTH-1:0]          m_req_addr,
    input  logic                                          m_rsp_vld,
    output logic                                          m_rsp_rdy,
    input  logic [constants_pkg::DATA_WIDTH-1:0]          m_rsp_data,
    output logic [$clog2(MAX_OUTSTANDING):0]              outstanding_cnt,
    output logic                                          err_unexpected_rsp
);
    localparam int AW = constants_pkg::ADDR_WIDTH;
    localparam int IW = $clog2(NUM_CLIENTS);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;

    typedef enum logic {REQ_IDLE, REQ_BUSY} req_state_e;

    req_state_e                             state_q;
    logic [AW-1:0]                          addr_q;
    logic [IW-1:0]                          rr_q;
    logic [MAX_OUTSTANDING-1:0][IW-1:0]     tag_q;
    logic [PW-1:0]                          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]                          cnt_q, cnt_d;

    logic                                   hs, load, pop, empty, full;
    logic                                   gnt_vld;
    logic [IW-1:0]                          gnt_idx, head;
    logic [IW:0]                            rr_sum;

    assign hs    = m_req_vld & m_req_rdy;
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(MAX_OUTSTANDING));
    assign head  = tag_q[rd_ptr_q];

    // Round-robin search starting at rr_q, wrapping at NUM_CLIENTS.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_sum  = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            rr_sum = {1'b0, rr_q} + (IW+1)'(k);
            if (rr_sum >= (IW+1)'(NUM_CLIENTS))
                rr_sum = rr_sum - (IW+1)'(NUM_CLIENTS);
            if (!gnt_vld && c_req_vld[rr_sum[IW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_sum[IW-1:0];
            end
        end
    end

    // Full is judged on the registered count, so a same-cycle pop does not free a slot.
    assign load = rst_n && (state_q == REQ_IDLE || hs) && !full && gnt_vld;

    always_comb begin
        c_req_rdy = '0;
        if (load)
            c_req_rdy[gnt_idx] = 1'b1;
    end

    assign m_req_vld  = (state_q == REQ_BUSY);
    assign m_req_addr = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REQ_IDLE;
            addr_q  <= '0;
            rr_q    <= '0;
        end else begin
            if (load) begin
                addr_q <= c_req_addr[gnt_idx*AW +: AW];
                rr_q   <= (gnt_idx == IW'(NUM_CLIENTS-1)) ? '0 : gnt_idx + 1'b1;
            end
            case (state_q)
                REQ_IDLE: if (load) state_q <= REQ_BUSY;
                REQ_BUSY: if (hs && !load) state_q <= REQ_IDLE;
                default:  state_q <= REQ_IDLE;
            endcase
        end
    end

    assign m_rsp_rdy  = !empty && c_rsp_rdy[head];
    assign pop        = m_rsp_vld && m_rsp_rdy;
    assign c_rsp_data = empty ? '0 : m_rsp_data;

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_lane
        gpu_mem_req_arb_rsp_lane u_lane (
            .sel_i (!empty && head == IW'(i)),
            .vld_i (m_rsp_vld),
            .vld_o (c_rsp_vld[i])
        );
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({load, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (load) begin
                tag_q[wr_ptr_q] <= gnt_idx;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    assign outstanding_cnt = cnt_q;

`ifdef GPU_MEM_REQ_ERR_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if (m_rsp_vld && empty)
            err_q <= 1'b1;
    end
    assign err_unexpected_rsp = err_q;
`else
    assign err_unexpected_rsp = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_mem_req_arb.sv
// Directed bench for gpu_mem_req_arb: reset, single request, fairness,
// backpressure, FIFO full, response ordering and the unexpected-response flag.
module tb_gpu_mem_req_arb;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef GPU_MEM_REQ_ERR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    c_req_vld, c_req_rdy, c_rsp_vld, c_rsp_rdy;
    logic [N*AW-1:0] c_req_addr;
    logic [DW-1:0]   c_rsp_data, m_rsp_data;
    logic            m_req_vld, m_req_rdy, m_rsp_vld, m_rsp_rdy, err_unexpected_rsp;
    logic [AW-1:0]   m_req_addr;
    logic [2:0]      outstanding_cnt;

    int total = 0;
    int bad   = 0;

    gpu_mem_req_arb #(.NUM_CLIENTS(N), .MAX_OUTSTANDING(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .c_req_vld          (c_req_vld),
        .c_req_rdy          (c_req_rdy),
        .c_req_addr         (c_req_addr),
        .c_rsp_vld          (c_rsp_vld),
        .c_rsp_rdy          (c_rsp_rdy),
        .c_rsp_data         (c_rsp_data),
        .m_req_vld          (m_req_vld),
        .m_req_rdy          (m_req_rdy),
        .m_req_addr         (m_req_addr),
        .m_rsp_vld          (m_rsp_vld),
        .m_rsp_rdy          (m_rsp_rdy),
        .m_rsp_data         (m_rsp_data),
        .outstanding_cnt    (outstanding_cnt),
        .err_unexpected_rsp (err_unexpected_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        c_req_addr[i*AW +: AW] = a;
    endtask

    task automatic rst_seq();
        rst_n      = 1'b0;
        c_req_vld  = '0;
        m_req_rdy  = 1'b0;
        m_rsp_vld  = 1'b0;
        c_rsp_rdy  = '1;
        m_rsp_data = '0;
        #1;
        chk("rst_cnt", 32'(outstanding_cnt), 0);
        chk("rst_mvld", 32'(m_req_vld), 0);
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b1;
        c_req_vld  = '0;
        c_req_addr = '0;
        m_req_rdy  = 1'b0;
        m_rsp_vld  = 1'b0;
        c_rsp_rdy  = '0;
        m_rsp_data = '0;
        #2;
        // Reset state, with stimulus active to show FIFO-derived outputs stay quiet.
        rst_n      = 1'b0;
        c_req_vld  = '1;
        m_req_rdy  = 1'b1;
        m_rsp_vld  = 1'b1;
        c_rsp_rdy  = '1;
        m_rsp_data = 32'h55;
        cyc(); cyc();
        chk("reset_mvld", 32'(m_req_vld), 0);
        chk("reset_maddr", m_req_addr, 0);
        chk("reset_cnt", 32'(outstanding_cnt), 0);
        chk("reset_crsp_vld", 32'(c_rsp_vld), 0);
        chk("reset_mrsp_rdy", 32'(m_rsp_rdy), 0);
        chk("reset_crsp_data", c_rsp_data, 0);
        chk("reset_err", 32'(err_unexpected_rsp), 0);
        chk("reset_creq_rdy", 32'(c_req_rdy), 0);
        c_req_vld = '0; m_req_rdy = 1'b0; m_rsp_vld = 1'b0; m_rsp_data = '0;
        rst_n = 1'b1;
        cyc();

        // Single request from client 2.
        m_req_rdy = 1'b1;
        c_req_vld = 4'b0100;
        set_addr(2, 32'h40);
        #1;
        chk("single_rdy", 32'(c_req_rdy), 32'b0100);
        chk("single_mvld0", 32'(m_req_vld), 0);
        cyc();
        c_req_vld = '0;
        #1;
        chk("single_mvld", 32'(m_req_vld), 1);
        chk("single_maddr", m_req_addr, 32'h40);
        chk("single_cnt1", 32'(outstanding_cnt), 1);
        chk("single_rdy_off", 32'(c_req_rdy), 0);
        cyc();
        #1;
        chk("single_mvld_drop", 32'(m_req_vld), 0);
        m_rsp_vld  = 1'b1;
        m_rsp_data = 32'hAB;
        #1;
        chk("single_rsp_vld", 32'(c_rsp_vld), 32'b0100);
        chk("single_rsp_data", c_rsp_data, 32'hAB);
        chk("single_mrsp_rdy", 32'(m_rsp_rdy), 1);
        cyc();
        m_rsp_vld = 1'b0;
        #1;
        chk("single_cnt0", 32'(outstanding_cnt), 0);
        chk("single_rsp_idle", 32'(c_rsp_vld), 0);

        // Fairness: all clients valid, responses drain one per cycle.
        rst_seq();
        m_req_rdy = 1'b1;
        c_req_vld = 4'b1111;
        #1;
        chk("rr_g0", 32'(c_req_rdy), 32'b0001);
        cyc();
        m_rsp_vld = 1'b1;
        #1;
        chk("rr_g1", 32'(c_req_rdy), 32'b0010);
        chk("rr_rsp0", 32'(c_rsp_vld), 32'b0001);
        cyc(); #1;
        chk("rr_g2", 32'(c_req_rdy), 32'b0100);
        chk("rr_rsp1", 32'(c_rsp_vld), 32'b0010);
        cyc(); #1;
        chk("rr_g3", 32'(c_req_rdy), 32'b1000);
        chk("rr_rsp2", 32'(c_rsp_vld), 32'b0100);
        cyc(); #1;
        chk("rr_g4", 32'(c_req_rdy), 32'b0001);
        chk("rr_rsp3", 32'(c_rsp_vld), 32'b1000);
        chk("rr_cnt", 32'(outstanding_cnt), 1);
        cyc();
        c_req_vld = '0;
        m_rsp_vld = 1'b0;
        #1;
        chk("rr_inflight", 32'(outstanding_cnt), 1);

        // Mid-operation reset discards the in-flight entry.
        rst_seq();
        #1;
        chk("midrst_cnt", 32'(outstanding_cnt), 0);
        chk("midrst_mvld", 32'(m_req_vld), 0);

        // Backpressure on the memory request channel.
        set_addr(0, 32'h100);
        set_addr(1, 32'h10);
        set_addr(2, 32'h200);
        set_addr(3, 32'h300);
        m_req_rdy = 1'b0;
        c_req_vld = 4'b0010;
        #1;
        chk("bp_rdy", 32'(c_req_rdy), 32'b0010);
        cyc();
        c_req_vld = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_mvld", 32'(m_req_vld), 1);
            chk("bp_maddr", m_req_addr, 32'h10);
            chk("bp_no_rdy", 32'(c_req_rdy), 0);
            cyc();
        end
        m_req_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(c_req_rdy), 32'b0100);
        cyc();
        c_req_vld = '0;
        #1;
        chk("bp_next_addr", m_req_addr, 32'h200);
        chk("bp_next_vld", 32'(m_req_vld), 1);
        chk("bp_cnt", 32'(outstanding_cnt), 2);

        // FIFO full: no load in the pop cycle, resume one cycle later.
        rst_seq();
        m_req_rdy = 1'b1;
        c_req_vld = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("full_fill_rdy", 32'(c_req_rdy), 32'(1 << i));
            chk("full_fill_cnt", 32'(outstanding_cnt), 32'(i));
            cyc();
        end
        #1;
        chk("full_cnt4", 32'(outstanding_cnt), 4);
        chk("full_no_rdy", 32'(c_req_rdy), 0);
        cyc(); #1;
        chk("full_no_rdy2", 32'(c_req_rdy), 0);
        chk("full_mvld_idle", 32'(m_req_vld), 0);
        m_rsp_vld = 1'b1;
        #1;
        chk("full_pop_no_rdy", 32'(c_req_rdy), 0);
        chk("full_pop_rsp", 32'(c_rsp_vld), 32'b0001);
        cyc();
        m_rsp_vld = 1'b0;
        #1;
        chk("full_after_pop_cnt", 32'(outstanding_cnt), 3);
        chk("full_resume_rdy", 32'(c_req_rdy), 32'b0001);
        cyc();
        c_req_vld = '0;
        #1;
        chk("full_refill_cnt", 32'(outstanding_cnt), 4);
        chk("full_refill_addr", m_req_addr, 32'h100);

        // In-order responses for clients 3,0,3 with client 0 stalling.
        rst_seq();
        m_req_rdy = 1'b1;
        c_rsp_rdy = 4'b1110;
        c_req_vld = 4'b1000;
        #1;
        chk("ord_g3a", 32'(c_req_rdy), 32'b1000);
        cyc();
        c_req_vld = 4'b0001;
        #1;
        chk("ord_g0", 32'(c_req_rdy), 32'b0001);
        cyc();
        c_req_vld = 4'b1000;
        #1;
        chk("ord_g3b", 32'(c_req_rdy), 32'b1000);
        cyc();
        c_req_vld  = '0;
        m_rsp_vld  = 1'b1;
        m_rsp_data = 32'hD1;
        #1;
        chk("ord_cnt3", 32'(outstanding_cnt), 3);
        chk("ord_d1_vld", 32'(c_rsp_vld), 32'b1000);
        chk("ord_d1_data", c_rsp_data, 32'hD1);
        chk("ord_d1_rdy", 32'(m_rsp_rdy), 1);
        cyc();
        m_rsp_data = 32'hD2;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ord_d2_stall_vld", 32'(c_rsp_vld), 32'b0001);
            chk("ord_d2_stall_rdy", 32'(m_rsp_rdy), 0);
            cyc();
        end
        c_rsp_rdy = 4'b1111;
        #1;
        chk("ord_d2_vld", 32'(c_rsp_vld), 32'b0001);
        chk("ord_d2_data", c_rsp_data, 32'hD2);
        chk("ord_d2_rdy", 32'(m_rsp_rdy), 1);
        cyc();
        m_rsp_data = 32'hD3;
        #1;
        chk("ord_d3_vld", 32'(c_rsp_vld), 32'b1000);
        chk("ord_d3_data", c_rsp_data, 32'hD3);
        cyc();
        m_rsp_vld = 1'b0;
        #1;
        chk("ord_cnt0", 32'(outstanding_cnt), 0);

        // Unexpected response while the FIFO is empty.
        rst_seq();
        m_rsp_vld = 1'b1;
        #1;
        chk("err_rdy_empty", 32'(m_rsp_rdy), 0);
        chk("err_crsp_empty", 32'(c_rsp_vld), 0);
        chk("err_pre", 32'(err_unexpected_rsp), 0);
        cyc();
        m_rsp_vld = 1'b0;
        #1;
        chk("err_set", 32'(err_unexpected_rsp), 32'(EXP_ERR));
        cyc(); cyc();
        #1;
        chk("err_sticky", 32'(err_unexpected_rsp), 32'(EXP_ERR));
        rst_n = 1'b0;
        #1;
        chk("err_cleared", 32'(err_unexpected_rsp), 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gpu_mem_req_arb.md
GPU_MEM_REQ_ARB -- requirements
Module: gpu_mem_req_arb

Interface
REQ-001 The block SHALL have parameter NUM_CLIENTS, default 4, giving the number of client request ports (2..8).
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 4, giving the maximum number of unanswered memory requests (power of 2, 2..16).
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port c_req_vld  input  NUM_CLIENTS  per-client request valid.
REQ-006 The block SHALL have port c_req_rdy  output  NUM_CLIENTS  per-client request accept.
REQ-007 The block SHALL have port c_req_addr  input  NUM_CLIENTS*constants_pkg::ADDR_WIDTH  per-client address, client i at slice i.
REQ-008 The block SHALL have port c_rsp_vld  output  NUM_CLIENTS  per-client response valid.
REQ-009 The block SHALL have port c_rsp_rdy  input  NUM_CLIENTS  per-client response accept.
REQ-010 The block SHALL have port c_rsp_data  output  constants_pkg::DATA_WIDTH  response data, shared by all clients.
REQ-011 The block SHALL have ports m_req_vld (output, 1), m_req_rdy (input, 1) and m_req_addr (output, constants_pkg::ADDR_WIDTH), forming the memory request channel as initiator.
REQ-012 The block SHALL have ports m_rsp_vld (input, 1), m_rsp_rdy (output, 1) and m_rsp_data (input, constants_pkg::DATA_WIDTH), forming the memory response channel as initiator.
REQ-013 The block SHALL have port outstanding_cnt  output  $clog2(MAX_OUTSTANDING)+1  number of entries in the tag FIFO.
REQ-014 The block SHALL have port err_unexpected_rsp  output  1  sticky error flag (see Configuration).

Function
REQ-015 The block SHALL provide a one-entry request register (REQ_IDLE/REQ_BUSY) that drives m_req_vld and m_req_addr directly from flops.
REQ-016 In REQ_BUSY, m_req_vld=1 and m_req_addr SHALL stay stable until the cycle in which m_req_vld&&m_req_rdy.
REQ-017 A load SHALL be allowed when (state==REQ_IDLE or handshake this cycle) and outstanding_cnt<MAX_OUTSTANDING; back-to-back requests are issued with no bubble.
REQ-018 On a load, the block SHALL grant exactly one valid client by round-robin, with the search starting at the client after the last grant.
REQ-019 c_req_rdy[i] SHALL be 1 only for the granted client in the load cycle, and 0 for all other clients and in all other cycles.
REQ-020 On a load, the block SHALL capture the granted address into m_req_addr and push the granted index into the tag FIFO (depth MAX_OUTSTANDING).
REQ-021 Memory responses are in order; the FIFO head SHALL select the destination client.
REQ-022 With the FIFO non-empty and head==h: c_rsp_vld[h]=m_rsp_vld, all other c_rsp_vld=0, m_rsp_rdy=c_rsp_rdy[h], c_rsp_data=m_rsp_data (combinational, zero latency).
REQ-023 The FIFO SHALL pop on m_rsp_vld&&m_rsp_rdy.
REQ-024 Simultaneous push and pop SHALL leave outstanding_cnt unchanged.
REQ-025 When the FIFO is empty, m_rsp_rdy SHALL be 0 and all c_rsp_vld SHALL be 0.
REQ-026 When the FIFO is full, no load SHALL occur even if a pop happens in the same cycle; loading resumes on the next cycle.
REQ-027 FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-028 A client SHALL be allowed to deassert c_req_vld without a grant; the block keeps no per-client state.

Reset
REQ-029 On rst_n=0 (asynchronous), the block SHALL set state=REQ_IDLE, m_req_vld=0, m_req_addr=0, FIFO empty, outstanding_cnt=0, round-robin pointer so that client 0 is searched first, and err_unexpected_rsp=0.
REQ-030 During reset, all outputs derived combinationally from the FIFO SHALL be 0.
REQ-031 A reset asserted mid-operation SHALL discard in-flight requests; responses to them are not expected afterwards.

Configuration
REQ-032 With macro GPU_MEM_REQ_ERR_CHECK_EN defined, err_unexpected_rsp SHALL be set the cycle after m_rsp_vld=1 while the FIFO is empty, and SHALL stay set until reset.
REQ-033 Without GPU_MEM_REQ_ERR_CHECK_EN, err_unexpected_rsp SHALL be tied to 0 and no checking logic SHALL be built.

Verification
REQ-034 Single request: client 2 requests addr 0x40, m_req_rdy=1 -> c_req_rdy[2] pulses one cycle, m_req_vld/addr 0x40 next cycle, outstanding_cnt=1; response data 0xAB -> c_rsp_vld[2] with data 0xAB, outstanding_cnt=0.
REQ-035 Fairness: all 4 clients hold c_req_vld, m_req_rdy=1 -> grant order 0,1,2,3,0, one per cycle.
REQ-036 Backpressure: m_req_rdy=0 for 5 cycles with client 1 addr 0x10 loaded -> m_req_vld=1, addr 0x10 stable, no further c_req_rdy.
REQ-037 Full: MAX_OUTSTANDING=4, 4 requests accepted with no responses -> outstanding_cnt=4, all c_req_rdy=0; one response returned -> the next load occurs one cycle after the pop.
REQ-038 Ordering: requests issued for clients 3,0,3 and responses D1,D2,D3 returned with c_rsp_rdy[0]=0 for 3 cycles -> D1 goes to client 3, D2 stalls (m_rsp_rdy=0) then goes to client 0, D3 goes to client 3.
REQ-039 Error check (macro defined): m_rsp_vld=1 with outstanding_cnt=0 -> err_unexpected_rsp=1 the next cycle, held until rst_n=0.
